pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Stall/flush scheduler for the five-stage pipeline. Consumes the taken-branch/jump decision from the execute stage, the decode and execute instructions, and the data-memory busy flag. Drives the PC enable plus the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and flushes, inserts load-use bubbles, and watches for a hung memory. Keeps saturating performance counters for stall, flush and load-use events.

## Interface
- `CNT_W`, 16: width of each performance counter.
- `TIMEOUT`, 64: consecutive `lsu_busy` cycles that raise `mem_timeout`; legal range 2..2^16-1.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `instr_D`  in  32: instruction in decode.
- `instr_E`  in  32: instruction in execute.
- `pc_sel_E`  in  1: redirect taken in execute (branch taken, JAL, JALR).
- `lsu_busy`  in  1: data memory cannot complete the MEM-stage access this cycle.
- `pc_en`  out  1: PC register load enable.
- `en_FD`, `en_DE`, `en_EM`, `en_MW`  out  1 each: pipeline register enables.
- `flush_FD`, `flush_DE`  out  1 each: synchronous clear of the register to a NOP (0x00000013) on the next edge.
- `mem_timeout`  out  1: sticky hung-memory error.
- `stall_cnt`, `flush_cnt`, `lu_cnt`  out  CNT_W each: saturating event counters.

## Operation
- Decode fields: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- rs1 is used by opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111. rs2 is used by 0110011, 0100011, 1100011.
- Load-use hazard (`lu`): all of the following hold.
  - instr_E opcode is 0000011.
  - rd_E != 0.
  - (rs1 used by instr_D and rs1_D == rd_E) or (rs2 used by instr_D and rs2_D == rd_E).
- States: RUN, WAIT, ERR.
- Per-cycle priority, highest first: rst > ERR > freeze (lsu_busy) > redirect (pc_sel_E) > lu > normal.
- Outputs by condition:
  - rst: pc_en=0, all en=0, flush_FD=flush_DE=1.
  - ERR: pc_en=0, all en=0, flushes 0.
  - Freeze (lsu_busy=1 in RUN/WAIT): pc_en=0, all en=0, flushes 0. pc_sel_E and lu are ignored. The branch stays in EX and redirects on the first unfrozen cycle.
  - Redirect: all enables 1, flush_FD=1, flush_DE=1. Any simultaneous lu is discarded and not counted.
  - lu: pc_en=0, en_FD=0, en_DE=1 with flush_DE=1 (one bubble), en_EM=en_MW=1.
  - Normal: all enables 1, flushes 0.
- Transitions:
  - RUN -> WAIT when lsu_busy=1.
  - WAIT -> RUN when lsu_busy=0.
  - WAIT -> ERR when lsu_busy=1 and wait_cnt == TIMEOUT-1.
  - ERR persists until rst.
- wait_cnt (16-bit): counts up in WAIT while lsu_busy=1. Cleared to 0 on entering RUN and on rst.
- mem_timeout = (state == ERR).
- Counters, each saturating at 2^CNT_W-1 and never wrapping:
  - stall_cnt +1 per freeze cycle and per lu bubble.
  - flush_cnt +1 per redirect cycle.
  - lu_cnt +1 per lu bubble.
  - No counter increments in ERR or during rst.

## Timing
- Reset values: state RUN, wait_cnt 0, mem_timeout 0, all counters 0.
- Outputs during the rst cycle are as listed under rst above.
- Enables and flushes are combinational from current state and inputs. They are valid in the same cycle as the stimulus; no added latency.
- Counters and mem_timeout are registered: visible one cycle after the event.
- lu bubble lasts exactly one cycle. The next cycle the load is in MEM and lu deasserts, unless a new load is in EX.
- A freeze of N cycles holds every pipeline register for N cycles. Redirect or lu resolves on cycle N+1.
- Counting from the first lsu_busy=1 cycle in RUN, the first cycle in ERR is the (TIMEOUT+1)th consecutive busy cycle. mem_timeout reads 1 that cycle.
- If lsu_busy drops on the same cycle wait_cnt reaches TIMEOUT-1, the next state is RUN, not ERR.
- rst asserted mid-freeze or in ERR returns to RUN on the next edge. Counters clear on that same edge.

## Test plan
- Load-use: instr_E=lw x5,0(x1) (0x0000A283), instr_D=add x6,x5,x2 (0x00228333). Required: pc_en=0, en_FD=0, flush_DE=1 for exactly one cycle; lu_cnt=1, stall_cnt=1 the next cycle.
- No false hazard: same load with rd=x0, then instr_D=lui x5 (rs unused). Required: no bubble; lu_cnt stays 0.
- Redirect + lu same cycle: pc_sel_E=1 with the load-use pair above. Required: flush_FD=flush_DE=1, pc_en=1, flush_cnt=1, lu_cnt=0.
- Freeze with pending branch: lsu_busy=1 for 3 cycles with pc_sel_E=1. Required:
  - all enables 0 for 3 cycles, flushes 0;
  - cycle 4 performs the redirect;
  - stall_cnt=3, flush_cnt=1.
- Timeout (TIMEOUT=4): lsu_busy held high. Required: mem_timeout=1 from the 5th busy cycle and held after lsu_busy drops. Then rst for one cycle: mem_timeout=0, state RUN, counters 0.
- Saturation (CNT_W=4): 20 consecutive freeze cycles (TIMEOUT=64). Required: stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: load-use bubbles, redirect flushes,
// memory freeze with hang detection, and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_instr_D,
    input  logic [31:0]      i_instr_E,
    input  logic             i_pc_sel_E,
    input  logic             i_lsu_busy,
    output logic             o_pc_en,
    output logic             o_en_FD,
    output logic             o_en_DE,
    output logic             o_en_EM,
    output logic             o_en_MW,
    output logic             o_flush_FD,
    output logic             o_flush_DE,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_lu_cnt
);

    localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_lu_cnt;
    logic        w_freeze, w_redir, w_bubble;

    function automatic logic f_uses_rs1(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b1100111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic f_uses_rs2(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    logic [6:0] w_op_D, w_op_E;
    logic [4:0] w_rs1_D, w_rs2_D, w_rd_E;
    logic       w_lu;

    assign w_op_D  = i_instr_D[6:0];
    assign w_rs1_D = i_instr_D[19:15];
    assign w_rs2_D = i_instr_D[24:20];
    assign w_op_E  = i_instr_E[6:0];
    assign w_rd_E  = i_instr_E[11:7];

    assign w_lu = (w_op_E == 7'b0000011) && (w_rd_E != 5'd0) &&
                  ((f_uses_rs1(w_op_D) && (w_rs1_D == w_rd_E)) ||
                   (f_uses_rs2(w_op_D) && (w_rs2_D == w_rd_E)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_wait_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // wait_cnt counts every consecutive busy cycle, so ERR is entered on the
    // (TIMEOUT+1)th busy cycle counted from the first one seen in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        o_pc_en     = 1'b1;
        o_en_FD     = 1'b1;
        o_en_DE     = 1'b1;
        o_en_EM     = 1'b1;
        o_en_MW     = 1'b1;
        o_flush_FD  = 1'b0;
        o_flush_DE  = 1'b0;
        w_freeze    = 1'b0;
        w_redir     = 1'b0;
        w_bubble    = 1'b0;
        if (i_rst) begin
            {o_pc_en, o_en_FD, o_en_DE, o_en_EM, o_en_MW} = 5'b0;
            o_flush_FD  = 1'b1;
            o_flush_DE  = 1'b1;
            w_state_nxt = RUN;
            w_wait_nxt  = 16'd0;
        end else if (r_state == ERR) begin
            {o_pc_en, o_en_FD, o_en_DE, o_en_EM, o_en_MW} = 5'b0;
        end else if (i_lsu_busy) begin
            {o_pc_en, o_en_FD, o_en_DE, o_en_EM, o_en_MW} = 5'b0;
            w_freeze = 1'b1;
            if (r_state == WAIT && r_wait_cnt == WAIT_LAST) begin
                w_state_nxt = ERR;
            end else begin
                w_state_nxt = WAIT;
                w_wait_nxt  = r_wait_cnt + 16'd1;
            end
        end else begin
            w_state_nxt = RUN;
            w_wait_nxt  = 16'd0;
            if (i_pc_sel_E) begin
                o_flush_FD = 1'b1;
                o_flush_DE = 1'b1;
                w_redir    = 1'b1;
            end else if (w_lu) begin
                o_pc_en    = 1'b0;
                o_en_FD    = 1'b0;
                o_flush_DE = 1'b1;
                w_bubble   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_lu_cnt    <= '0;
        end else begin
            if ((w_freeze || w_bubble) && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redir && r_flush_cnt != CNT_MAX)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_bubble && r_lu_cnt != CNT_MAX)
                r_lu_cnt <= r_lu_cnt + 1'b1;
        end
    end

    assign o_mem_timeout = (r_state == ERR);
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;
    assign o_lu_cnt      = r_lu_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (short timeout / narrow counters) on shared
// stimulus, checked every cycle against a behavioural model plus directed literal checks.
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] LW5  = 32'h0000A283;
    localparam logic [31:0] ADD6 = 32'h00228333;
    localparam logic [31:0] LUI5 = 32'h000052B7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_D = NOP, instr_E = NOP;
    logic        pc_sel = 1'b0, busy = 1'b0;

    logic [1:0]  pc_en, en_FD, en_DE, en_EM, en_MW, fl_FD, fl_DE, tmo;
    logic [15:0] stall_a, flush_a, lu_a;
    logic [3:0]  stall_b, flush_b, lu_b;

    int nchk = 0;
    int nerr = 0;
    bit run_chk = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(16), .TIMEOUT(4)) u_a (
        .i_clk(clk), .i_rst(rst), .i_instr_D(instr_D), .i_instr_E(instr_E),
        .i_pc_sel_E(pc_sel), .i_lsu_busy(busy),
        .o_pc_en(pc_en[0]), .o_en_FD(en_FD[0]), .o_en_DE(en_DE[0]), .o_en_EM(en_EM[0]),
        .o_en_MW(en_MW[0]), .o_flush_FD(fl_FD[0]), .o_flush_DE(fl_DE[0]),
        .o_mem_timeout(tmo[0]), .o_stall_cnt(stall_a), .o_flush_cnt(flush_a), .o_lu_cnt(lu_a));

    pipe_hazard_ctrl #(.CNT_W(4), .TIMEOUT(64)) u_b (
        .i_clk(clk), .i_rst(rst), .i_instr_D(instr_D), .i_instr_E(instr_E),
        .i_pc_sel_E(pc_sel), .i_lsu_busy(busy),
        .o_pc_en(pc_en[1]), .o_en_FD(en_FD[1]), .o_en_DE(en_DE[1]), .o_en_EM(en_EM[1]),
        .o_en_MW(en_MW[1]), .o_flush_FD(fl_FD[1]), .o_flush_DE(fl_DE[1]),
        .o_mem_timeout(tmo[1]), .o_stall_cnt(stall_b), .o_flush_cnt(flush_b), .o_lu_cnt(lu_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // {pc_en, en_FD, en_DE, en_EM, en_MW, flush_FD, flush_DE}
    function automatic logic [6:0] dvec(input int k);
        return {pc_en[k], en_FD[k], en_DE[k], en_EM[k], en_MW[k], fl_FD[k], fl_DE[k]};
    endfunction

    function automatic logic [31:0] dcnt(input int k, input int which);
        if (k == 0) return (which == 0) ? 32'(stall_a) : (which == 1) ? 32'(flush_a) : 32'(lu_a);
        return (which == 0) ? 32'(stall_b) : (which == 1) ? 32'(flush_b) : 32'(lu_b);
    endfunction

    // ---------------- behavioural model ----------------
    int  m_to[2]  = '{4, 64};
    int  m_max[2] = '{65535, 15};
    bit  m_init[2], m_err[2];
    int  m_streak[2], m_cnt[2][3];

    function automatic bit m_lu(input logic [31:0] d, input logic [31:0] e);
        logic [6:0] od;
        bit r1, r2;
        od = d[6:0];
        r1 = od inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        r2 = od inside {7'h33, 7'h23, 7'h63};
        if (e[6:0] != 7'h03 || e[11:7] == 5'd0) return 1'b0;
        return (r1 && d[19:15] == e[11:7]) || (r2 && d[24:20] == e[11:7]);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    always @(negedge clk) if (run_chk) begin
        for (int k = 0; k < 2; k++) begin
            logic [6:0] ev;
            bit lu;
            lu = m_lu(instr_D, instr_E);
            if (rst)            ev = 7'b0000011;
            else if (m_err[k])  ev = 7'b0000000;
            else if (busy)      ev = 7'b0000000;
            else if (pc_sel)    ev = 7'b1111111;
            else if (lu)        ev = 7'b0011101;
            else                ev = 7'b1111100;
            chk($sformatf("ctl%0d", k), 32'(dvec(k)), 32'(ev));
            if (m_init[k]) begin
                chk($sformatf("tmo%0d", k), 32'(tmo[k]), 32'(m_err[k]));
                chk($sformatf("stall%0d", k), dcnt(k, 0), 32'(m_cnt[k][0]));
                chk($sformatf("flush%0d", k), dcnt(k, 1), 32'(m_cnt[k][1]));
                chk($sformatf("lu%0d", k), dcnt(k, 2), 32'(m_cnt[k][2]));
            end
            if (rst) begin
                m_init[k] = 1'b1;
                m_err[k] = 1'b0;
                m_streak[k] = 0;
                m_cnt[k] = '{0, 0, 0};
            end else if (!m_err[k]) begin
                if (busy) begin
                    m_streak[k]++;
                    m_cnt[k][0] = sat(m_cnt[k][0], m_max[k]);
                    if (m_streak[k] == m_to[k]) m_err[k] = 1'b1;
                end else begin
                    m_streak[k] = 0;
                    if (pc_sel) m_cnt[k][1] = sat(m_cnt[k][1], m_max[k]);
                    else if (lu) begin
                        m_cnt[k][0] = sat(m_cnt[k][0], m_max[k]);
                        m_cnt[k][2] = sat(m_cnt[k][2], m_max[k]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic s, input logic b);
        instr_D = d; instr_E = e; pc_sel = s; busy = b;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(NOP, NOP, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_ctl", 32'(dvec(0)), 32'h03);
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [8];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h6F};
        r = $urandom;
        return {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:12],
                5'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
    endfunction

    initial begin
        #1;
        do_reset();

        // load-use bubble
        drive(ADD6, LW5, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_ctl", 32'({pc_en[0], en_FD[0], fl_DE[0]}), 32'b001);
        next_cycle();
        drive(ADD6, NOP, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_once", 32'(pc_en[0]), 32'd1);
        chk("lu_cnt", 32'(lu_a), 32'd1);
        chk("lu_stall", 32'(stall_a), 32'd1);
        next_cycle();

        // no false hazard
        do_reset();
        drive(32'h00000033, 32'h00000003, 1'b0, 1'b0);
        @(negedge clk);
        chk("rd0_ctl", 32'(dvec(0)), 32'h7C);
        next_cycle();
        drive(LUI5, LW5, 1'b0, 1'b0);
        @(negedge clk);
        chk("lui_ctl", 32'(dvec(0)), 32'h7C);
        next_cycle();
        drive(NOP, NOP, 1'b0, 1'b0);
        @(negedge clk);
        chk("nofalse_lu", 32'(lu_a), 32'd0);
        next_cycle();

        // redirect beats load-use
        do_reset();
        drive(ADD6, LW5, 1'b1, 1'b0);
        @(negedge clk);
        chk("redir_ctl", 32'(dvec(0)), 32'h7F);
        next_cycle();
        drive(NOP, NOP, 1'b0, 1'b0);
        @(negedge clk);
        chk("redir_flush", 32'(flush_a), 32'd1);
        chk("redir_lu", 32'(lu_a), 32'd0);
        next_cycle();

        // freeze with pending branch
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(ADD6, LW5, 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("frz_ctl%0d", i), 32'(dvec(0)), 32'h00);
            next_cycle();
        end
        drive(ADD6, LW5, 1'b1, 1'b0);
        @(negedge clk);
        chk("frz_redir", 32'(dvec(0)), 32'h7F);
        next_cycle();
        drive(NOP, NOP, 1'b0, 1'b0);
        @(negedge clk);
        chk("frz_stall", 32'(stall_a), 32'd3);
        chk("frz_flush", 32'(flush_a), 32'd1);
        next_cycle();

        // timeout on the short-timeout instance
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(NOP, NOP, 1'b0, 1'b1);
            @(negedge clk);
            if (i == 4) chk("tmo_early", 32'(tmo[0]), 32'd0);
            if (i == 5) begin
                chk("tmo_set", 32'(tmo[0]), 32'd1);
                chk("tmo_stall", 32'(stall_a), 32'd4);
            end
            next_cycle();
        end
        drive(NOP, NOP, 1'b1, 1'b0);
        @(negedge clk);
        chk("tmo_sticky", 32'(tmo[0]), 32'd1);
        chk("err_ctl", 32'(dvec(0)), 32'h00);
        next_cycle();
        do_reset();
        @(negedge clk);
        chk("tmo_clr", 32'(tmo[0]), 32'd0);
        chk("tmo_cnt_clr", 32'(stall_a), 32'd0);
        chk("tmo_run", 32'(dvec(0)), 32'h7C);
        next_cycle();

        // saturation on the narrow-counter instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(NOP, NOP, 1'b0, 1'b1);
            next_cycle();
        end
        drive(NOP, NOP, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat_stall", 32'(stall_b), 32'd15);
        chk("sat_notmo", 32'(tmo[1]), 32'd0);
        next_cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            instr_D = rnd_instr();
            instr_E = ($urandom_range(0, 2) == 0) ? {instr_D[31:12], 5'($urandom_range(0, 3)), 7'h03}
                                                  : rnd_instr();
            pc_sel = ($urandom_range(0, 5) == 0);
            busy = ($urandom_range(0, 4) == 0);
            next_cycle();
        end

        @(negedge clk);
        run_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
